// File: rtl/uio_uart_tx_bridge.sv
// uio_uart_tx_bridge: accepts 20-bit words from the fabric into a small FIFO and
// transmits each as three 8N1 UART bytes (low byte first, top nibble last)
// on a single pad bit, with pad output-enable and sticky overflow reporting.
module uio_uart_tx_bridge #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] word_i,
  input  logic        word_valid_i,
  output logic        word_ready_o,
  output logic        tx_o,
  output logic        tx_oeb_o,
  output logic        busy_o,
  output logic        overflow_o,
  input  logic        clear_overflow_i
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [19:0] hold_q, hold_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic        out_en_q, out_en_d;

  logic [19:0] mem [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // FIFO status and handshake
  // ---------------------------------------------------------------------------
  logic       fifo_empty;
  logic       fifo_full;
  logic       push;
  logic       pop;
  logic       baud_last;
  logic [7:0] cur_byte;
  logic       tx_bit;

  // The extra pointer bit distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // Readiness ignores a same-cycle pop so that the ready path stays short.
  assign word_ready_o = out_en_q & ~fifo_full;
  assign push         = word_valid_i & word_ready_o;
  assign tx_oeb_o     = ~out_en_q;
  assign overflow_o   = overflow_q;
  assign busy_o       = (state_q != IDLE) | ~fifo_empty;
  assign baud_last    = (baud_cnt_q == BAUD_LAST);
  assign tx_o         = tx_bit;

  // Select the byte of the held word currently on the line.
  always_comb begin
    cur_byte = 8'h00;
    case (byte_idx_q)
      2'd0:    cur_byte = hold_q[7:0];
      2'd1:    cur_byte = hold_q[15:8];
      default: cur_byte = {4'b0000, hold_q[19:16]};
    endcase
  end

  // Pointer, overflow and output-enable next-state logic.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    out_en_d   = 1'b1;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    // A new drop wins over a clear in the same cycle.
    if (word_valid_i && !word_ready_o) begin
      overflow_d = 1'b1;
    end else if (clear_overflow_i) begin
      overflow_d = 1'b0;
    end
  end

  // Transmit FSM: next state, counters, hold register and line level.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    byte_idx_d = byte_idx_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    pop        = 1'b0;
    tx_bit     = 1'b1;
    case (state_q)
      IDLE: begin
        tx_bit = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          hold_d     = mem[rd_ptr_q[AW-1:0]];
          byte_idx_d = 2'd0;
          bit_cnt_d  = 3'd0;
          baud_cnt_d = 16'd0;
          state_d    = START;
        end
      end
      START: begin
        tx_bit = 1'b0;
        if (baud_last) begin
          baud_cnt_d = 16'd0;
          bit_cnt_d  = 3'd0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      DATA: begin
        tx_bit = cur_byte[bit_cnt_q];
        if (baud_last) begin
          baud_cnt_d = 16'd0;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      STOP: begin
        tx_bit = 1'b1;
        if (baud_last) begin
          baud_cnt_d = 16'd0;
          bit_cnt_d  = 3'd0;
          // Bytes of one word run back to back; the last returns to IDLE for one cycle.
          if (byte_idx_q < 2'd2) begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AW-1:0]] <= word_i;
    end
  end

  // State and control registers; reset returns the line to idle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hold_q     <= 20'h00000;
      byte_idx_q <= 2'd0;
      bit_cnt_q  <= 3'd0;
      baud_cnt_q <= 16'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      out_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      byte_idx_q <= byte_idx_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      out_en_q   <= out_en_d;
    end
  end

endmodule

// File: tb/tb_uio_uart_tx_bridge.sv
// Testbench for uio_uart_tx_bridge: directed pushes feed an expected-byte
// scoreboard; a UART line monitor decodes tx_o and checks each byte in order.
module tb_uio_uart_tx_bridge;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [19:0] word_i;
  logic        word_valid_i;
  logic        word_ready_o;
  logic        tx_o;
  logic        tx_oeb_o;
  logic        busy_o;
  logic        overflow_o;
  logic        clear_overflow_i;

  int checks = 0;
  int errors = 0;

  logic [7:0] sb[$];
  int         gap_q[$];

  uio_uart_tx_bridge #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .word_i          (word_i),
    .word_valid_i    (word_valid_i),
    .word_ready_o    (word_ready_o),
    .tx_o            (tx_o),
    .tx_oeb_o        (tx_oeb_o),
    .busy_o          (busy_o),
    .overflow_o      (overflow_o),
    .clear_overflow_i(clear_overflow_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one word for one cycle; the caller states whether it should be taken.
  task automatic push(input logic [19:0] w, input logic exp_acc, input logic clr);
    @(negedge clk);
    word_i           = w;
    word_valid_i     = 1'b1;
    clear_overflow_i = clr;
    chk("word_ready", 32'(word_ready_o), 32'(exp_acc));
    if (exp_acc) begin
      sb.push_back(w[7:0]);
      sb.push_back(w[15:8]);
      sb.push_back({4'b0000, w[19:16]});
    end
    @(posedge clk);
    #1;
    word_valid_i     = 1'b0;
    clear_overflow_i = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", 32'(busy_o), 32'(0));
    chk("sb_empty", 32'(sb.size()), 32'(0));
  endtask

  // Line monitor: frame timing counted from the first start-bit cycle.
  initial begin
    int         cyc_ctr;
    int         last_end;
    int         mon_cnt;
    logic       mon_active;
    logic [7:0] rx_byte;
    logic [7:0] exp_byte;
    cyc_ctr    = 0;
    last_end   = 0;
    mon_cnt    = 0;
    mon_active = 1'b0;
    rx_byte    = 8'h00;
    forever begin
      @(negedge clk);
      cyc_ctr++;
      if (rst_n !== 1'b1) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (tx_o === 1'b0) begin
          mon_active = 1'b1;
          mon_cnt    = 0;
          gap_q.push_back(cyc_ctr - last_end - 1);
        end
      end else begin
        mon_cnt++;
        if (mon_cnt == 2) begin
          chk("start_bit", 32'(tx_o), 32'(0));
        end
        if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % 4) == 0) begin
          rx_byte[(mon_cnt - 6) / 4] = tx_o;
        end
        if (mon_cnt == 38) begin
          chk("stop_bit", 32'(tx_o), 32'(1));
          chk("rx_expected_pending", 32'(sb.size() > 0), 32'(1));
          if (sb.size() > 0) begin
            exp_byte = sb.pop_front();
            chk("rx_byte", 32'(rx_byte), 32'(exp_byte));
            $display("byte rx=%02h exp=%02h", rx_byte, exp_byte);
          end
        end
        if (mon_cnt == 39) begin
          mon_active = 1'b0;
          last_end   = cyc_ctr;
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] burst [6];
    int          cyc;
    int          found;
    int          zeros;

    word_i           = 20'h00000;
    word_valid_i     = 1'b0;
    clear_overflow_i = 1'b0;
    rst_n            = 1'b0;

    // Reset values while rst_n is held low across clock edges.
    #23;
    chk("rst_tx", 32'(tx_o), 32'(1));
    chk("rst_oeb", 32'(tx_oeb_o), 32'(1));
    chk("rst_busy", 32'(busy_o), 32'(0));
    chk("rst_ready", 32'(word_ready_o), 32'(0));
    chk("rst_ovf", 32'(overflow_o), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 32'(word_ready_o), 32'(0));
    @(posedge clk);
    #1;
    chk("ready_after_edge", 32'(word_ready_o), 32'(1));
    chk("oeb_after_edge", 32'(tx_oeb_o), 32'(0));

    // Single word: latency, frame length, busy drop.
    push(20'hA5C3F, 1'b1, 1'b0);
    @(negedge clk);
    chk("lat_idle_tx", 32'(tx_o), 32'(1));
    chk("lat_idle_busy", 32'(busy_o), 32'(1));
    @(negedge clk);
    chk("lat_start_tx", 32'(tx_o), 32'(0));
    cyc = 0;
    while (busy_o === 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("word_cycles", 32'(cyc), 32'(30 * CPB));
    drain(10);

    // Two back-to-back words: no gap between bytes, one idle cycle between words.
    gap_q.delete();
    push(20'h12345, 1'b1, 1'b0);
    push(20'h6789A, 1'b1, 1'b0);
    drain(400);
    chk("gap_count", 32'(gap_q.size()), 32'(6));
    if (gap_q.size() == 6) begin
      chk("gap_byte1", 32'(gap_q[1]), 32'(0));
      chk("gap_byte2", 32'(gap_q[2]), 32'(0));
      chk("gap_word", 32'(gap_q[3]), 32'(1));
      chk("gap_byte4", 32'(gap_q[4]), 32'(0));
    end

    // Burst from idle: the first word moves to the hold register one cycle after
    // landing, so five are taken and the sixth is refused.
    burst[0] = 20'h0BEEF;
    burst[1] = 20'h1CAFE;
    burst[2] = 20'h2D00D;
    burst[3] = 20'h3F00F;
    burst[4] = 20'h4A11A;
    burst[5] = 20'h5DEAD;
    for (int i = 0; i < 6; i++) begin
      push(burst[i], (i < 5), 1'b0);
    end
    @(negedge clk);
    chk("ovf_set", 32'(overflow_o), 32'(1));
    push(20'h11111, 1'b0, 1'b1);
    @(negedge clk);
    chk("ovf_set_beats_clear", 32'(overflow_o), 32'(1));
    @(negedge clk);
    clear_overflow_i = 1'b1;
    @(posedge clk);
    #1;
    clear_overflow_i = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", 32'(overflow_o), 32'(0));
    drain(900);

    // Reset during byte1 DATA with a second word queued.
    push(20'h2468A, 1'b1, 1'b0);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (tx_o === 1'b0) found = 1;
    end
    chk("rst_test_start_seen", 32'(found), 32'(1));
    repeat (20) @(negedge clk);
    push(20'h13579, 1'b1, 1'b0);
    repeat (25) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", 32'(tx_o), 32'(1));
    chk("async_rst_oeb", 32'(tx_oeb_o), 32'(1));
    chk("async_rst_busy", 32'(busy_o), 32'(0));
    chk("async_rst_ready", 32'(word_ready_o), 32'(0));
    repeat (3) @(negedge clk);
    sb.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(word_ready_o), 32'(1));
    chk("post_rst_oeb", 32'(tx_oeb_o), 32'(0));
    chk("post_rst_fifo_empty", 32'(busy_o), 32'(0));
    zeros = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_o !== 1'b1) zeros++;
    end
    chk("no_residual_bits", 32'(zeros), 32'(0));

    // Extreme data and pointer wrap: nine pushes after reset.
    push(20'hFFFFF, 1'b1, 1'b0);
    push(20'h00000, 1'b1, 1'b0);
    push(20'h0F0F0, 1'b1, 1'b0);
    push(20'hABCDE, 1'b1, 1'b0);
    push(20'h55AA5, 1'b1, 1'b0);
    drain(900);
    push(20'h96969, 1'b1, 1'b0);
    push(20'h3C3C3, 1'b1, 1'b0);
    push(20'h7E7E7, 1'b1, 1'b0);
    push(20'h81818, 1'b1, 1'b0);
    drain(900);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
